// File: rtl/hazard_stall_controller.sv
// Front-end pipeline sequencer: load-use interlock, jump/branch flush and
// data-memory wait freeze, with a saturating stall counter and sticky timeout.
module hazard_stall_controller #(
  parameter int unsigned LOAD_DELAY = 1,
  parameter int unsigned WAIT_MAX   = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout,
  output logic [1:0]       state
);

  localparam int unsigned BC_W = 4;
  localparam int unsigned WC_W = 16;
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(LOAD_DELAY - 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t          cur;
  state_t          nxt;
  state_t          eff;
  logic [BC_W-1:0] bc;
  logic [BC_W-1:0] bc_n;
  logic [WC_W-1:0] wc;
  logic [WC_W-1:0] wc_n;
  logic            timeout_n;
  logic            rt_used;
  logic            hazard;
  logic            pc_c;
  logic            ifid_c;
  logic            flush_c;
  logic            bubble_c;
  logic            hold_c;

  // rt is a source operand only for R-type, sw, beq and bne
  assign rt_used = (id_opcode == 6'b000000) || (id_opcode == 6'b101011) ||
                   (id_opcode == 6'b000100) || (id_opcode == 6'b000101);
  assign hazard  = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_used));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= RUN;
      bc          <= '0;
      wc          <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      cur         <= nxt;
      bc          <= bc_n;
      wc          <= wc_n;
      mem_timeout <= timeout_n;
      if (!pc_c && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Leaving MEM_WAIT behaves exactly like the state it resumes into
  always_comb begin
    nxt       = RUN;
    bc_n      = bc;
    wc_n      = '0;
    timeout_n = mem_timeout;
    pc_c      = 1'b1;
    ifid_c    = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    hold_c    = 1'b0;
    eff       = cur;
    if (cur == MEM_WAIT)
      eff = (bc != '0) ? LOAD_STALL : RUN;

    if (mem_busy) begin
      pc_c   = 1'b0;
      ifid_c = 1'b0;
      hold_c = 1'b1;
      nxt    = MEM_WAIT;
      wc_n   = (wc == WC_MAX) ? wc : wc + WC_W'(1);
      if (wc_n == WC_MAX)
        timeout_n = 1'b1;
    end else if (ex_branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      bc_n     = '0;
    end else if (eff == LOAD_STALL) begin
      pc_c     = 1'b0;
      ifid_c   = 1'b0;
      bubble_c = 1'b1;
      bc_n     = (bc != '0) ? bc - BC_W'(1) : '0;
      nxt      = (bc > BC_W'(1)) ? LOAD_STALL : RUN;
    end else if (hazard) begin
      pc_c     = 1'b0;
      ifid_c   = 1'b0;
      bubble_c = 1'b1;
      bc_n     = BC_LOAD;
      nxt      = (LOAD_DELAY > 1) ? LOAD_STALL : RUN;
    end else if (id_jump) begin
      flush_c = 1'b1;
    end
  end

  // Reset overrides the combinational controls immediately
  assign pc_write    = reset_n & pc_c;
  assign ifid_write  = reset_n & ifid_c;
  assign ifid_flush  = reset_n & flush_c;
  assign idex_bubble = ~reset_n | bubble_c;
  assign pipe_hold   = reset_n & hold_c;
  assign state       = cur;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: instance a uses defaults, instance b uses LOAD_DELAY=3 and
// WAIT_MAX=3; both share one stimulus set.
module tb_hazard_stall_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        id_jump;
  logic        ex_branch_taken;
  logic        mem_busy;

  logic        pc_a, ifid_a, flush_a, bubble_a, hold_a, timeout_a;
  logic [15:0] cnt_a;
  logic [1:0]  state_a;
  logic        pc_b, ifid_b, flush_b, bubble_b, hold_b, timeout_b;
  logic [15:0] cnt_b;
  logic [1:0]  state_b;

  int errors = 0;
  int checks = 0;

  hazard_stall_controller u_a (
    .clock(clock), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_a), .ifid_write(ifid_a), .ifid_flush(flush_a),
    .idex_bubble(bubble_a), .pipe_hold(hold_a), .stall_count(cnt_a),
    .mem_timeout(timeout_a), .state(state_a)
  );

  hazard_stall_controller #(.LOAD_DELAY(3), .WAIT_MAX(3), .CNT_W(16)) u_b (
    .clock(clock), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_b), .ifid_write(ifid_b), .ifid_flush(flush_b),
    .idex_bubble(bubble_b), .pipe_hold(hold_b), .stall_count(cnt_b),
    .mem_timeout(timeout_b), .state(state_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    id_opcode       = 6'd0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    id_jump         = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
  endtask

  task automatic hazard_rs;
    idle();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd8;
    id_rs       = 5'd8;
  endtask

  task automatic pulse_reset;
    idle();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc_a, 0);
    check("rst_ifid", ifid_a, 0);
    check("rst_bubble", bubble_a, 1);
    check("rst_hold", hold_a, 0);
    check("rst_state", state_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_timeout", timeout_a, 0);
    reset_n = 1'b1;
    tick();

    // load-use on rs, single bubble
    hazard_rs();
    #1;
    check("t1_pc", pc_a, 0);
    check("t1_ifid", ifid_a, 0);
    check("t1_bubble", bubble_a, 1);
    tick();
    idle();
    #1;
    check("t1_pc_after", pc_a, 1);
    check("t1_state", state_a, 0);
    check("t1_cnt", cnt_a, 1);
    tick();

    // rt match only counts when the opcode reads rt
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_opcode = 6'b001000;
    #1;
    check("t2_addi_pc", pc_a, 1);
    tick();
    id_opcode = 6'b101011;
    #1;
    check("t2_sw_pc", pc_a, 0);
    check("t2_sw_bubble", bubble_a, 1);
    tick();
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_opcode = 6'd0;
    #1;
    check("t2_r0_pc", pc_a, 1);
    check("t2_cnt", cnt_a, 2);
    tick();
    idle();
    id_jump = 1'b1;
    #1;
    check("jmp_pc", pc_a, 1);
    check("jmp_flush", flush_a, 1);
    check("jmp_bubble", bubble_a, 0);
    tick();

    // branch beats hazard
    hazard_rs();
    ex_branch_taken = 1'b1;
    #1;
    check("t3_pc", pc_a, 1);
    check("t3_flush", flush_a, 1);
    check("t3_bubble", bubble_a, 1);
    tick();
    idle();
    #1;
    check("t3_state", state_a, 0);
    check("t3_pc_after", pc_a, 1);
    tick();

    // branch in second stall cycle with LOAD_DELAY=3
    pulse_reset();
    hazard_rs();
    #1;
    check("t3b_pc", pc_b, 0);
    tick();
    idle();
    #1;
    check("t3b_state_ls", state_b, 1);
    check("t3b_pc_ls", pc_b, 0);
    ex_branch_taken = 1'b1;
    #1;
    check("t3b_br_pc", pc_b, 1);
    check("t3b_br_flush", flush_b, 1);
    check("t3b_br_bubble", bubble_b, 1);
    tick();
    idle();
    #1;
    check("t3b_state", state_b, 0);
    check("t3b_pc_after", pc_b, 1);
    check("t3b_cnt", cnt_b, 1);
    tick();

    // memory wait during LOAD_STALL with bc=1
    pulse_reset();
    hazard_rs();
    #1;
    tick();
    idle();
    #1;
    check("t4_state_ls", state_b, 1);
    tick();
    mem_busy = 1'b1;
    #1;
    check("t4_hold", hold_b, 1);
    check("t4_pc", pc_b, 0);
    check("t4_bubble", bubble_b, 0);
    check("t4_state_pre", state_b, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_state_mw", state_b, 2);
      check("t4_hold_mw", hold_b, 1);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check("t4_exit_state", state_b, 2);
    check("t4_exit_pc", pc_b, 0);
    check("t4_exit_bubble", bubble_b, 1);
    check("t4_exit_hold", hold_b, 0);
    tick();
    #1;
    check("t4_run_state", state_b, 0);
    check("t4_run_pc", pc_b, 1);
    check("t4_cnt", cnt_b, 7);
    tick();

    // timeout with WAIT_MAX=3
    pulse_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_timeout_busy", timeout_b, (i >= 3) ? 1 : 0);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check("t5_timeout_drop", timeout_b, 1);
    check("t5_state_drop", state_b, 2);
    check("t5_timeout_a", timeout_a, 0);
    tick();
    #1;
    check("t5_timeout_sticky", timeout_b, 1);
    check("t5_state_run", state_b, 0);
    tick();

    // async reset mid LOAD_STALL
    pulse_reset();
    hazard_rs();
    #1;
    tick();
    idle();
    #1;
    check("t6_state_ls", state_b, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_state", state_b, 0);
    check("t6_rst_cnt", cnt_b, 0);
    check("t6_rst_pc", pc_b, 0);
    check("t6_rst_bubble", bubble_b, 1);
    check("t6_rst_timeout", timeout_b, 0);
    reset_n = 1'b1;
    #1;
    check("t6_rel_pc", pc_b, 1);
    check("t6_rel_state", state_b, 0);
    check("t6_rel_cnt", cnt_b, 0);
    tick();
    #1;
    check("t6_next_pc", pc_b, 1);
    check("t6_next_cnt", cnt_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
